dcache_port_arbiter: RTL
========================

// Module: dcache_port_arbiter
// PURPOSE
//  Shares the single data-cache request port between three requesters: committed-store writebacks (ROB),
//  scalar loads (load/store unit second stage) and vector memory beats (vector LSU). Fixed priority
//  st > ld > vec with anti-starvation promotion, vector burst locking, and one registered output stage.
//  Sits between the requesters and the non-blocking data cache.
// PARAMETERS
//  DATA_WIDTH     32  data bits per request
//  ADDR_BITS      32  address bits
//  R_WIDTH        6   scalar destination register bits
//  MICROOP        5   microoperation bits
//  ROB_TICKET     3   ROB ticket bits
//  STARVE_LIMIT   8   waiting cycles after which ld/vec is promoted above st (>=1)
//  VEC_MAX_BURST  8   max vector beats per lock before forced release (>=1)
// PORTS
//  clk            in   1                  clock; all state on rising edge
//  rst            in   1                  synchronous, active-high reset
//  st_valid/st_ready      in/out 1        committed-store handshake
//  st_addr/st_data        in  ADDR_BITS/DATA_WIDTH
//  st_microop             in  MICROOP
//  ld_valid/ld_ready      in/out 1        scalar-load handshake
//  ld_addr/ld_microop     in  ADDR_BITS/MICROOP
//  ld_dest/ld_ticket      in  R_WIDTH/ROB_TICKET
//  ld_blocked             out 1           ld_valid & ~ld_ready (feeds LSU cache_load_blocked)
//  vec_valid/vec_ready    in/out 1        vector-beat handshake
//  vec_we/vec_last        in  1/1         beat is store / final beat of burst
//  vec_addr/vec_data      in  ADDR_BITS/DATA_WIDTH
//  cache_valid/cache_ready out/in 1       cache request handshake
//  cache_we               out 1           1 = write
//  cache_addr/cache_data  out ADDR_BITS/DATA_WIDTH
//  cache_microop          out MICROOP     vec beats: 0
//  cache_tag              out ROB_TICKET+R_WIDTH  {ticket,dest} for loads, 0 otherwise
//  cache_src              out 2           00 st, 01 ld, 10 vec
// BEHAVIOUR
//  - Reset: all outputs 0 (all *_ready=0, cache_valid=0, ld_blocked=0), FSM=ARB, counters=0. Reset
//    mid-operation drops the held request; requesters re-issue.
//  - Output reg: load_en = ~cache_valid | cache_ready. At most one *_ready high per cycle, only if load_en.
//    Accepted request appears on cache_* next cycle (latency 1); held stable while cache_valid & ~cache_ready.
//  - Starve counters (ld, vec): +1 each cycle valid & ~ready, saturate at STARVE_LIMIT, clear on accept/~valid.
//  - FSM ARB: winner = starved requester (ld before vec if both) else st > ld > vec.
//    vec accepted with vec_last=0 -> LOCK, beat_cnt=1. vec_last=1 -> stay ARB.
//  - FSM LOCK: only vec may be granted (st_ready=ld_ready=0); beat_cnt +1 per accepted beat.
//    -> ARB on accepted beat with vec_last=1, or when beat_cnt reaches VEC_MAX_BURST (forced release;
//    vec re-arbitrates remaining beats, its starve counter restarts at 0). Idle gaps keep the lock.
//  - Simultaneous st/ld/vec valid with no starvation: st wins; ld_blocked=1 that cycle.
//  - cache_we: st=1, ld=0, vec=vec_we. Requests are never reordered within a source.
// CONFIGURATION
//  DCARB_PERF_CNT_EN defined: adds outputs perf_st_cnt, perf_ld_cnt, perf_vec_cnt (32b each, accepted
//  requests, wrap at 2^32) and perf_starve_cnt (32b, promotions); all reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. st,ld,vec valid together, cache_ready=1 -> grants st, ld, vec on 3 consecutive cycles; cache_src 00,01,10.
//  2. st_valid held 1, ld_valid=1, STARVE_LIMIT=8 -> ld granted on cycle 9 of waiting, then st resumes.
//  3. vec burst 4 beats (last on 4th) vs st_valid -> 4 vec beats back-to-back, st_ready=0 until release.
//  4. vec burst 12 beats, VEC_MAX_BURST=8 -> lock drops after beat 8, st granted next, vec resumes.
//  5. cache_ready=0 for 5 cycles with ld held -> cache_* stable, all *_ready=0, ld_blocked=1; ready=1 -> drains.
//  6. rst=1 during LOCK with cache_valid=1 -> next cycle cache_valid=0, FSM=ARB, counters (and perf) 0.

Source files
------------

// File: rtl/dcache_port_arbiter.sv
// Data-cache port arbiter: shares one cache request port between committed
// stores (st), scalar loads (ld) and vector memory beats (vec).
//
// Fixed priority st > ld > vec. A ld or vec requester that has waited
// STARVE_LIMIT cycles is promoted above st. A vector burst that is not
// finished after its first beat locks the port for up to VEC_MAX_BURST beats.
// The winning request is registered into a single output stage with
// latency 1. It is held stable while cache_valid_o & ~cache_ready_i.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   st_*                committed-store request (valid/ready, addr, data, microop)
//   ld_*                scalar-load request (valid/ready, addr, microop, dest, ticket)
//   ld_blocked_o        ld_valid_i & ~ld_ready_o
//   vec_*               vector beat (valid/ready, we, last, addr, data)
//   cache_*             registered request to the data cache (valid/ready,
//                       we, addr, data, microop, tag, src)
//
// Optional feature macro: DCARB_PERF_CNT_EN adds perf_st_cnt_o,
// perf_ld_cnt_o, perf_vec_cnt_o (accepted requests) and perf_starve_cnt_o
// (promoted grants). All are 32-bit wrapping counters.

module dcache_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_BITS     = 32,
    parameter int R_WIDTH       = 6,
    parameter int MICROOP       = 5,
    parameter int ROB_TICKET    = 3,
    parameter int STARVE_LIMIT  = 8,
    parameter int VEC_MAX_BURST = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          st_valid_i,
    output logic                          st_ready_o,
    input  logic [ADDR_BITS-1:0]          st_addr_i,
    input  logic [DATA_WIDTH-1:0]         st_data_i,
    input  logic [MICROOP-1:0]            st_microop_i,

    input  logic                          ld_valid_i,
    output logic                          ld_ready_o,
    input  logic [ADDR_BITS-1:0]          ld_addr_i,
    input  logic [MICROOP-1:0]            ld_microop_i,
    input  logic [R_WIDTH-1:0]            ld_dest_i,
    input  logic [ROB_TICKET-1:0]         ld_ticket_i,
    output logic                          ld_blocked_o,

    input  logic                          vec_valid_i,
    output logic                          vec_ready_o,
    input  logic                          vec_we_i,
    input  logic                          vec_last_i,
    input  logic [ADDR_BITS-1:0]          vec_addr_i,
    input  logic [DATA_WIDTH-1:0]         vec_data_i,

    output logic                          cache_valid_o,
    input  logic                          cache_ready_i,
    output logic                          cache_we_o,
    output logic [ADDR_BITS-1:0]          cache_addr_o,
    output logic [DATA_WIDTH-1:0]         cache_data_o,
    output logic [MICROOP-1:0]            cache_microop_o,
    output logic [ROB_TICKET+R_WIDTH-1:0] cache_tag_o,
    output logic [1:0]                    cache_src_o
`ifdef DCARB_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_st_cnt_o,
    output logic [31:0]                   perf_ld_cnt_o,
    output logic [31:0]                   perf_vec_cnt_o,
    output logic [31:0]                   perf_starve_cnt_o
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(VEC_MAX_BURST + 1);
    localparam int TW = ROB_TICKET + R_WIDTH;

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_MAX  = BW'(VEC_MAX_BURST);

    localparam logic [1:0] SRC_ST  = 2'b00;
    localparam logic [1:0] SRC_LD  = 2'b01;
    localparam logic [1:0] SRC_VEC = 2'b10;

    typedef enum logic {
        ARB,
        LOCK
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [SW-1:0]   ld_starve_q, ld_starve_d;
    logic [SW-1:0]   vec_starve_q, vec_starve_d;

    logic                  cache_valid_q;
    logic                  cache_we_q, cache_we_d;
    logic [ADDR_BITS-1:0]  cache_addr_q, cache_addr_d;
    logic [DATA_WIDTH-1:0] cache_data_q, cache_data_d;
    logic [MICROOP-1:0]    cache_microop_q, cache_microop_d;
    logic [TW-1:0]         cache_tag_q, cache_tag_d;
    logic [1:0]            cache_src_q, cache_src_d;

    logic load_en;
    logic ld_starved;
    logic vec_starved;
    logic gnt_st;
    logic gnt_ld;
    logic gnt_vec;
    logic gnt_any;
    logic promo;

    // The output register can take a new request when it is empty or
    // its current request is being consumed this cycle.
    assign load_en     = ~cache_valid_q | cache_ready_i;
    assign ld_starved  = (ld_starve_q == STARVE_MAX);
    assign vec_starved = (vec_starve_q == STARVE_MAX);

    always_comb begin
        gnt_st  = 1'b0;
        gnt_ld  = 1'b0;
        gnt_vec = 1'b0;
        promo   = 1'b0;
        if (!rst_i && load_en) begin
            if (state_q == LOCK) begin
                gnt_vec = vec_valid_i;
            end else if (ld_valid_i && ld_starved) begin
                gnt_ld = 1'b1;
                promo  = 1'b1;
            end else if (vec_valid_i && vec_starved) begin
                gnt_vec = 1'b1;
                promo   = 1'b1;
            end else if (st_valid_i) begin
                gnt_st = 1'b1;
            end else if (ld_valid_i) begin
                gnt_ld = 1'b1;
            end else if (vec_valid_i) begin
                gnt_vec = 1'b1;
            end
        end
    end

    assign gnt_any      = gnt_st | gnt_ld | gnt_vec;
    assign st_ready_o   = gnt_st;
    assign ld_ready_o   = gnt_ld;
    assign vec_ready_o  = gnt_vec;
    assign ld_blocked_o = ~rst_i & ld_valid_i & ~gnt_ld;

    // Waiting counters saturate; any cycle without a pending wait clears them.
    always_comb begin
        ld_starve_d  = '0;
        vec_starve_d = '0;
        if (ld_valid_i && !gnt_ld) begin
            ld_starve_d = ld_starved ? ld_starve_q : ld_starve_q + SW'(1);
        end
        if (vec_valid_i && !gnt_vec) begin
            vec_starve_d = vec_starved ? vec_starve_q : vec_starve_q + SW'(1);
        end
    end

    // Burst lock: a first beat that is not last takes the lock.
    // The lock is released by the last beat or by the beat limit.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (gnt_vec) begin
            if (state_q == ARB) begin
                if (!vec_last_i && (BURST_MAX > BW'(1))) begin
                    state_d = LOCK;
                    beat_d  = BW'(1);
                end
            end else if (vec_last_i || (beat_q + BW'(1) == BURST_MAX)) begin
                state_d = ARB;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_comb begin
        cache_we_d      = cache_we_q;
        cache_addr_d    = cache_addr_q;
        cache_data_d    = cache_data_q;
        cache_microop_d = cache_microop_q;
        cache_tag_d     = cache_tag_q;
        cache_src_d     = cache_src_q;
        unique case (1'b1)
            gnt_st: begin
                cache_we_d      = 1'b1;
                cache_addr_d    = st_addr_i;
                cache_data_d    = st_data_i;
                cache_microop_d = st_microop_i;
                cache_tag_d     = '0;
                cache_src_d     = SRC_ST;
            end
            gnt_ld: begin
                cache_we_d      = 1'b0;
                cache_addr_d    = ld_addr_i;
                cache_data_d    = '0;
                cache_microop_d = ld_microop_i;
                cache_tag_d     = {ld_ticket_i, ld_dest_i};
                cache_src_d     = SRC_LD;
            end
            gnt_vec: begin
                cache_we_d      = vec_we_i;
                cache_addr_d    = vec_addr_i;
                cache_data_d    = vec_data_i;
                cache_microop_d = '0;
                cache_tag_d     = '0;
                cache_src_d     = SRC_VEC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ARB;
            beat_q          <= '0;
            ld_starve_q     <= '0;
            vec_starve_q    <= '0;
            cache_valid_q   <= 1'b0;
            cache_we_q      <= 1'b0;
            cache_addr_q    <= '0;
            cache_data_q    <= '0;
            cache_microop_q <= '0;
            cache_tag_q     <= '0;
            cache_src_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            ld_starve_q  <= ld_starve_d;
            vec_starve_q <= vec_starve_d;
            if (load_en) begin
                cache_valid_q <= gnt_any;
            end
            cache_we_q      <= cache_we_d;
            cache_addr_q    <= cache_addr_d;
            cache_data_q    <= cache_data_d;
            cache_microop_q <= cache_microop_d;
            cache_tag_q     <= cache_tag_d;
            cache_src_q     <= cache_src_d;
        end
    end

    assign cache_valid_o   = cache_valid_q;
    assign cache_we_o      = cache_we_q;
    assign cache_addr_o    = cache_addr_q;
    assign cache_data_o    = cache_data_q;
    assign cache_microop_o = cache_microop_q;
    assign cache_tag_o     = cache_tag_q;
    assign cache_src_o     = cache_src_q;

`ifdef DCARB_PERF_CNT_EN
    logic [31:0] perf_st_q;
    logic [31:0] perf_ld_q;
    logic [31:0] perf_vec_q;
    logic [31:0] perf_starve_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_st_q     <= '0;
            perf_ld_q     <= '0;
            perf_vec_q    <= '0;
            perf_starve_q <= '0;
        end else begin
            perf_st_q     <= perf_st_q + 32'(gnt_st);
            perf_ld_q     <= perf_ld_q + 32'(gnt_ld);
            perf_vec_q    <= perf_vec_q + 32'(gnt_vec);
            perf_starve_q <= perf_starve_q + 32'(promo);
        end
    end

    assign perf_st_cnt_o     = perf_st_q;
    assign perf_ld_cnt_o     = perf_ld_q;
    assign perf_vec_cnt_o    = perf_vec_q;
    assign perf_starve_cnt_o = perf_starve_q;
`endif

endmodule
